// File: rtl/ntt_stage_fwd.sv
// One streaming forward-NTT (Cooley-Tukey DIT) stage: twiddle multiply, then add/sub,
// followed by a delay commutator that regroups the pair stream for the next stage.
module ntt_stage_fwd #(
  parameter int Q             = 3329,
  parameter int DATA_WIDTH    = 12,
  parameter int FRAME_BEATS   = 128,
  parameter int MUL_LAT       = 3,
  parameter int REORDER_DEPTH = 2,
  parameter int TW_SHIFT      = 0,
  parameter int ROM_AW        = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_en,
  input  logic [1:0][DATA_WIDTH-1:0] in,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic                       out_en,
  output logic [1:0][DATA_WIDTH-1:0] out
);
  localparam int DW  = DATA_WIDTH;
  localparam int KW  = $clog2(FRAME_BEATS);
  localparam int D   = REORDER_DEPTH;
  localparam int L0  = MUL_LAT + 2;
  localparam int LAT = L0 + D;
  localparam int DB  = (D > 0) ? $clog2(D) : 0;
  localparam logic [2*DW-1:0] QP = (2*DW)'(Q);
  localparam logic [DW:0]     QX = (DW+1)'(Q);

  logic [LAT:1]  vld_pipe;
  logic [KW-1:0] k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      k        <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:1], in_en};
      k        <= in_en ? k + 1'b1 : '0;
    end
  end

  assign rom_addr = ROM_AW'(k >> TW_SHIFT);
  assign out_en   = vld_pipe[LAT];

  // Stage 1 lines a/b up with the synchronous ROM read
  logic [DW-1:0]   a1, b1;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   t_red;
  logic [DW-1:0]   t_pipe [MUL_LAT];
  logic [DW-1:0]   a_pipe [MUL_LAT];

  always_ff @(posedge clk) begin
    a1 <= in[0];
    b1 <= in[1];
  end

  assign prod  = (2*DW)'(b1) * (2*DW)'(rom_data);
  assign t_red = DW'(prod % QP);

  always_ff @(posedge clk) begin
    t_pipe[0] <= t_red;
    a_pipe[0] <= a1;
    for (int i = 1; i < MUL_LAT; i++) begin
      t_pipe[i] <= t_pipe[i-1];
      a_pipe[i] <= a_pipe[i-1];
    end
  end

  logic [DW-1:0] ad, t, y0_n, y1_n, y0, y1;
  logic [DW:0]   sum;

  assign ad   = a_pipe[MUL_LAT-1];
  assign t    = t_pipe[MUL_LAT-1];
  assign sum  = {1'b0, ad} + {1'b0, t};
  assign y0_n = (sum >= QX) ? DW'(sum - QX) : DW'(sum);
  assign y1_n = (ad >= t) ? ad - t : DW'({1'b0, ad} + QX - {1'b0, t});

  always_ff @(posedge clk) begin
    y0 <= y0_n;
    y1 <= y1_n;
  end

  logic [DW-1:0] d0, d1;

  generate
    if (D == 0) begin : g_nocomm
      assign d0 = y0;
      assign d1 = y1;
    end else begin : g_comm
      logic          y_en;
      logic [KW-1:0] ok;
      logic [DW-1:0] y1_dly [D];
      logic [DW-1:0] l0_dly [D];
      logic [DW-1:0] y1_d, lane0, lane1;

      assign y_en = vld_pipe[L0];

      // ok tracks the beat index of the pair currently in y0/y1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ok <= '0;
        else     ok <= y_en ? ok + 1'b1 : '0;
      end

      assign y1_d  = y1_dly[D-1];
      assign lane0 = ok[DB] ? y1_d : y0;
      assign lane1 = ok[DB] ? y0   : y1_d;

      always_ff @(posedge clk) begin
        y1_dly[0] <= y1;
        l0_dly[0] <= lane0;
        for (int i = 1; i < D; i++) begin
          y1_dly[i] <= y1_dly[i-1];
          l0_dly[i] <= l0_dly[i-1];
        end
      end

      assign d0 = l0_dly[D-1];
      assign d1 = lane1;
    end
  endgenerate

  // Delay lines are not reset, so data is masked to zero whenever out_en is low
  always_comb begin
    out = '0;
    if (out_en) begin
      out[0] = d0;
      out[1] = d1;
    end
  end
endmodule

// File: tb/tb_ntt_stage_fwd.sv
// Bench for ntt_stage_fwd: three instances (D=2, D=0, D=2 with TW_SHIFT=2) on a shared
// input stream, checked every cycle against a frame-level arithmetic model.
module tb_ntt_stage_fwd;
  localparam int Q = 3329;
  localparam int N = 2048;
  localparam int LATV [3] = '{7, 5, 7};
  localparam int DDV  [3] = '{2, 0, 2};
  localparam int TWSV [3] = '{0, 0, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_en = 1'b0;
  logic [1:0][11:0] din = '0;
  logic [6:0]       rom_addr [3];
  logic [11:0]      rom_data [3];
  logic             out_en   [3];
  logic [1:0][11:0] dout     [3];

  always #5 clk = ~clk;

  ntt_stage_fwd #(.REORDER_DEPTH(2), .TW_SHIFT(0)) u_d2 (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din), .rom_addr(rom_addr[0]),
    .rom_data(rom_data[0]), .out_en(out_en[0]), .out(dout[0]));
  ntt_stage_fwd #(.REORDER_DEPTH(0), .TW_SHIFT(0)) u_d0 (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din), .rom_addr(rom_addr[1]),
    .rom_data(rom_data[1]), .out_en(out_en[1]), .out(dout[1]));
  ntt_stage_fwd #(.REORDER_DEPTH(2), .TW_SHIFT(2)) u_tw (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din), .rom_addr(rom_addr[2]),
    .rom_data(rom_data[2]), .out_en(out_en[2]), .out(dout[2]));

  int rom_mode = 0;
  int wconst   = 17;

  function automatic int rom_f(int addr);
    return (rom_mode != 0) ? addr + 1 : wconst;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++) rom_data[i] <= 12'(rom_f(int'(rom_addr[i])));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int inst, input int at, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s u%0d cyc=%0d got=%0d exp=%0d", nm, inst, at, act, exp);
    end
  endtask

  // Input history seen by the model, plus what each instance produced
  int a_h [N], b_h [N], k_h [N];
  int w_h [3][N];
  bit en_h [N], chk_h [N];
  int o_en [3][N], o0 [3][N], o1 [3][N], oaddr [3][N];
  int last_rst = -1;
  bit chk_cur = 1'b0;

  function automatic int tw_mul(int i, int s);
    return (w_h[i][s] * b_h[s]) % Q;
  endfunction
  function automatic int y0f(int i, int s);
    return (a_h[s] + tw_mul(i, s)) % Q;
  endfunction
  function automatic int y1f(int i, int s);
    return (a_h[s] - tw_mul(i, s) + Q) % Q;
  endfunction

  always @(negedge clk) begin
    int n, s, e0, e1;
    bit ee;
    n = cyc;
    if (n < N) begin
      if (rst) last_rst = n;
      en_h[n]  = in_en && !rst;
      chk_h[n] = chk_cur && !rst;
      a_h[n]   = int'(din[0]);
      b_h[n]   = int'(din[1]);
      if (rst || n == 0) k_h[n] = 0;
      else k_h[n] = en_h[n-1] ? (k_h[n-1] + 1) % 128 : 0;
      for (int i = 0; i < 3; i++) begin
        w_h[i][n]   = rom_f((k_h[n] >> TWSV[i]) & 127);
        o_en[i][n]  = int'(out_en[i]);
        o0[i][n]    = int'(dout[i][0]);
        o1[i][n]    = int'(dout[i][1]);
        oaddr[i][n] = int'(rom_addr[i]);
        if (rst) begin
          check("rst_out_en", i, n, int'(out_en[i]), 0);
          check("rst_out", i, n, int'(dout[i]), 0);
        end else begin
          s  = n - LATV[i];
          ee = (s >= 0) && (s > last_rst) && en_h[s];
          check("out_en", i, n, int'(out_en[i]), int'(ee));
          if (ee && chk_h[s]) begin
            if (DDV[i] == 0) begin
              e0 = y0f(i, s); e1 = y1f(i, s);
            end else if ((k_h[s] & DDV[i]) == 0) begin
              e0 = y0f(i, s); e1 = y0f(i, s + DDV[i]);
            end else begin
              e0 = y1f(i, s - DDV[i]); e1 = y1f(i, s);
            end
            check("out0", i, n, int'(dout[i][0]), e0);
            check("out1", i, n, int'(dout[i][1]), e1);
          end
          if (en_h[n]) check("rom_addr", i, n, int'(rom_addr[i]), (k_h[n] >> TWSV[i]) & 127);
        end
      end
    end
  end

  task automatic beat(input bit en, input int a, input int b, input bit c);
    in_en = en; din[0] = 12'(a); din[1] = 12'(b); chk_cur = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 0, 0, 1'b0);
  endtask

  int c_t1, c_a, c_b, c_f1, cnt;
  int r0 [8] = '{0, 1, 0, 1, 4, 5, 4, 5};
  int r1 [8] = '{2, 3, 2, 3, 6, 7, 6, 7};

  initial begin
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) beat(1'b1, 5, 1, 1'b0);
    rst = 1'b0;
    idle(3);

    c_t1 = cyc;
    for (int j = 0; j < 128; j++) beat(1'b1, 5, 1, 1'b1);
    idle(10);

    wconst = 3328; c_a = cyc;
    for (int j = 0; j < 128; j++) beat(1'b1, 3328, 3328, 1'b1);
    idle(10);

    wconst = 0; c_b = cyc;
    for (int j = 0; j < 128; j++) beat(1'b1, j, 5, 1'b1);
    idle(10);

    rom_mode = 1; c_f1 = cyc;
    for (int j = 0; j < 256; j++) beat(1'b1, 0, 1, 1'b1);
    idle(5);

    for (int j = 0; j < 50; j++) beat(1'b1, $urandom_range(0, Q-1), $urandom_range(0, Q-1), 1'b0);
    idle(3);
    for (int j = 0; j < 128; j++) beat(1'b1, $urandom_range(0, Q-1), $urandom_range(0, Q-1), 1'b1);
    idle(5);

    for (int j = 0; j < 40; j++) beat(1'b1, $urandom_range(0, Q-1), $urandom_range(0, Q-1), 1'b0);
    rst = 1'b1;
    beat(1'b1, 1, 1, 1'b0);
    beat(1'b1, 1, 1, 1'b0);
    rst = 1'b0;
    idle(2);
    for (int j = 0; j < 128; j++) beat(1'b1, $urandom_range(0, Q-1), $urandom_range(0, Q-1), 1'b1);
    idle(15);

    // Hand-computed anchors for the model
    check("lit_en_pre",  0, c_t1+6,   o_en[0][c_t1+6],   0);
    check("lit_en_first",0, c_t1+7,   o_en[0][c_t1+7],   1);
    check("lit_en_last", 0, c_t1+134, o_en[0][c_t1+134], 1);
    check("lit_en_post", 0, c_t1+135, o_en[0][c_t1+135], 0);
    check("lit_const0",  0, c_t1+7,   o0[0][c_t1+7],     22);
    check("lit_const1",  0, c_t1+8,   o1[0][c_t1+8],     22);
    check("lit_const2",  0, c_t1+9,   o0[0][c_t1+9],     3317);
    check("lit_const3",  0, c_t1+134, o1[0][c_t1+134],   3317);
    check("lit_wrap_y0", 1, c_a+5,    o0[1][c_a+5],      0);
    check("lit_wrap_y1", 1, c_a+5,    o1[1][c_a+5],      3327);
    check("lit_wrap_d2", 0, c_a+9,    o1[0][c_a+9],      3327);
    check("lit_zero_w0", 1, c_b+5,    o0[1][c_b+5],      0);
    check("lit_zero_w1", 1, c_b+5,    o1[1][c_b+5],      0);
    for (int j = 0; j < 8; j++) begin
      check("lit_reord0", 0, c_b+7+j, o0[0][c_b+7+j], r0[j]);
      check("lit_reord1", 0, c_b+7+j, o1[0][c_b+7+j], r1[j]);
      check("lit_nord0",  1, c_b+5+j, o0[1][c_b+5+j], j);
      check("lit_nord1",  1, c_b+5+j, o1[1][c_b+5+j], j);
    end
    check("lit_addr12", 2, c_f1+12,  oaddr[2][c_f1+12],  3);
    check("lit_addr15", 2, c_f1+15,  oaddr[2][c_f1+15],  3);
    check("lit_addr0",  2, c_f1+128, oaddr[2][c_f1+128], 0);
    check("lit_tw_y13", 2, c_f1+20,  o0[2][c_f1+20],     4);
    cnt = 0;
    for (int j = 0; j < 256; j++) cnt += o_en[0][c_f1+7+j];
    check("lit_b2b_cnt", 0, c_f1+7,   cnt, 256);
    check("lit_b2b_end", 0, c_f1+263, o_en[0][c_f1+263], 0);
    check("lit_f1_b0",   0, c_f1+7,   o1[0][c_f1+7],     3);
    check("lit_f2_b0",   0, c_f1+135, o1[0][c_f1+135],   3);
    check("lit_f2_b2a",  0, c_f1+137, o0[0][c_f1+137],   3328);
    check("lit_f2_b2b",  0, c_f1+137, o1[0][c_f1+137],   3326);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
